// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential multiply/divide unit, one result bit per clock.
//   Multiply is a shift-add on operand magnitudes. Divide is a restoring
//   division on magnitudes. A final FIX cycle applies the signs for the
//   signed ops.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           request, sampled only in IDLE
//   op[1:0]         00 mult, 01 multu, 10 div, 11 divu
//   a, b            multiplicand/dividend, multiplier/divisor
//   busy            high in RUN and FIX
//   done            one-cycle pulse with the result valid
//   div_zero        pulse coincident with done on a divide by zero
//   hi, lo          {product} or {remainder, quotient}; held until next start
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mag_b;   // multiplicand / divisor magnitude
  logic             r_is_div;
  logic             r_signed;
  logic             r_neg_q;   // operand signs differ
  logic             r_neg_r;   // dividend negative

  // Operand sign/magnitude, computed from the live inputs at the accepting edge
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Multiply step: {hi,lo} shifts right; lo[0] is the current multiplier bit.
  logic [WIDTH:0]   w_sum;
  assign w_sum = {1'b0, hi} + (lo[0] ? {1'b0, r_mag_b} : '0);

  // Divide step: partial remainder in hi, dividend shifting out of lo while
  // quotient bits shift in. The remainder stays below the divisor, so the
  // shifted value fits WIDTH+1 bits and the top bit of the difference is
  // the borrow.
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;
  assign w_shift = {hi, lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_mag_b};
  assign w_ge    = ~w_diff[WIDTH];

  logic [2*WIDTH-1:0] w_prod_neg;
  assign w_prod_neg = ~{hi, lo} + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mag_b  <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            if (op[1] && (b == '0)) begin
              // Divide by zero: report straight away, no iterations
              r_state  <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              hi       <= a;
              lo       <= '1;
            end else begin
              r_state  <= RUN;
              busy     <= 1'b1;
              r_cnt    <= '0;
              r_mag_b  <= w_b_mag;
              r_is_div <= op[1];
              r_signed <= ~op[0];
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              hi       <= '0;
              lo       <= w_a_mag;
            end
          end
        end

        RUN: begin
          if (r_is_div) begin
            hi <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], w_ge};
          end else begin
            hi <= w_sum[WIDTH:1];
            lo <= {w_sum[0], lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= FIX;
        end

        FIX: begin
          if (r_signed) begin
            if (r_is_div) begin
              if (r_neg_q) lo <= ~lo + 1'b1;
              if (r_neg_r) hi <= ~hi + 1'b1;
            end else if (r_neg_q) begin
              {hi, lo} <= w_prod_neg;
            end
          end
          r_state <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end

        DONE: begin
          r_state  <= IDLE;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed table, random ops against a
// plain-arithmetic reference, hand sequences for start-ignore and reset abort,
// plus a WIDTH=8 instance. Latencies count the accepting edge as edge 1.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: straight arithmetic on the operand values
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] xa, xb,
                                    output logic [31:0] rh, rl, output logic rdz,
                                    output int lat);
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    sa = $signed(xa);
    sb = $signed(xb);
    rdz = 1'b0;
    lat = 34;
    case (o)
      2'b00: begin sp = longint'(sa) * longint'(sb); up = sp; rh = up[63:32]; rl = up[31:0]; end
      2'b01: begin up = 64'(xa) * 64'(xb); rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (xb == 32'h0) begin
          rdz = 1'b1; lat = 1; rh = xa; rl = 32'hFFFFFFFF;
        end else if (o == 2'b11) begin
          rl = xa / xb; rh = xa % xb;
        end else if (xa == 32'h80000000 && xb == 32'hFFFFFFFF) begin
          rl = xa; rh = 32'h0;
        end else begin
          rl = sa / sb; rh = sa % sb;
        end
      end
    endcase
  endfunction

  // Issue one op, scramble the inputs after acceptance, wait for done
  // (bounded), then check the result holds for one idle cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, xb,
                        output logic [31:0] rh, rl, output logic rdz,
                        output int lat, output int busy_err, output int hold_err);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk);
    lat = 1;
    busy_err = 0;
    hold_err = 0;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    while (!done && lat < 200) begin
      if (!busy || div_zero) busy_err++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (busy) busy_err++;
    rh = hi; rl = lo; rdz = div_zero;
    @(negedge clk);
    if (done || div_zero || busy || hi !== rh || lo !== rl) hold_err++;
  endtask

  task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] xa, xb,
                          input logic [31:0] eh, el, input logic edz, input int elat);
    logic [31:0] rh, rl;
    logic        rdz;
    int          lat, be, he;
    run_op(o, xa, xb, rh, rl, rdz, lat, be, he);
    chk({tag, ".hi"}, 64'(rh), 64'(eh));
    chk({tag, ".lo"}, 64'(rl), 64'(el));
    chk({tag, ".div_zero"}, 64'(rdz), 64'(edz));
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".busy_errors"}, 64'(be), 64'd0);
    chk({tag, ".hold_errors"}, 64'(he), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] xa, xb,
                      input logic [7:0] eh, el, input logic edz, input int elat);
    int lat;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = xa; b8 = xb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".hi"}, 64'(hi8), 64'(eh));
    chk({tag, ".lo"}, 64'(lo8), 64'(el));
    chk({tag, ".div_zero"}, 64'(dz8), 64'(edz));
  endtask

  vec_t tbl [10];

  initial begin
    logic [31:0] eh, el, xa, xb;
    logic        edz;
    int          elat, n, cnt_done, cnt_busy;
    logic [1:0]  o;

    tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
    tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
    tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    tbl[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    tbl[4] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    tbl[5] = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1};
    tbl[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    tbl[7] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 34};
    tbl[8] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 34};
    tbl[9] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #2;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat);

    for (int i = 0; i < 50; i++) begin
      o  = 2'($urandom_range(0, 3));
      xa = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       xb = 32'h0;
        1:       xb = 32'($urandom_range(1, 15));
        2:       xb = 32'hFFFFFFFF;
        default: xb = $urandom;
      endcase
      ref_model(o, xa, xb, eh, el, edz, elat);
      check_op($sformatf("rnd%0d", i), o, xa, xb, eh, el, edz, elat);
    end

    // Second start during RUN is ignored and not queued
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd7;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); n++; end
    @(negedge clk);
    start = 1'b1; a = 32'd9;
    @(posedge clk);
    n++;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("ignore.latency", 64'(n), 64'd34);
    chk("ignore.hi", 64'(hi), 64'd0);
    chk("ignore.lo", 64'(lo), 64'h23);
    cnt_done = 0; cnt_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("ignore.no_queued_done", 64'(cnt_done), 64'd0);
    chk("ignore.no_queued_busy", 64'(cnt_busy), 64'd0);

    // Reset mid-operation aborts immediately; start ignored while in reset
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("abort.no_done", 64'(cnt_done), 64'd0);
    chk("abort.no_busy", 64'(cnt_busy), 64'd0);
    check_op("after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34);

    // WIDTH = 8 instance
    run8("w8.divu", 2'b11, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 10);
    run8("w8.mult", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 10);
    run8("w8.div0", 2'b10, 8'h85, 8'h00, 8'h85, 8'hFF, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
